jtbubl_obj_draw: RTL and testbench



---
 rtl/jtbubl_obj_draw_if.sv | 46 ++++
 rtl/jtbubl_obj_draw.sv | 185 ++++++++++++++++++
 tb/tb_jtbubl_obj_draw.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtbubl_obj_draw_if.sv
// Object RAM read port, tile ROM request port and line-buffer write port
// of the object line renderer. The master side is the renderer.
interface jtbubl_obj_draw_if #(
    parameter int OBJN   = 64,
    parameter int CODEW  = 10,
    parameter int PALW   = 4,
    parameter int HEIGHT = 16
);
    localparam int AW = $clog2(OBJN);
    localparam int HB = $clog2(HEIGHT);
    localparam int DW = 19 + PALW + CODEW;

    logic [AW-1:0]       obj_addr;
    logic [DW-1:0]       obj_data;
    logic                rom_cs;
    logic [CODEW+HB:0]   rom_addr;
    logic [31:0]         rom_data;
    logic                rom_ok;
    logic [8:0]          line_addr;
    logic [PALW+3:0]     line_din;
    logic                line_we;

    modport master (
        output obj_addr,
        input  obj_data,
        output rom_cs,
        output rom_addr,
        input  rom_data,
        input  rom_ok,
        output line_addr,
        output line_din,
        output line_we
    );

    modport slave (
        input  obj_addr,
        output obj_data,
        input  rom_cs,
        input  rom_addr,
        output rom_data,
        output rom_ok,
        input  line_addr,
        input  line_din,
        input  line_we
    );
endinterface

// File: rtl/jtbubl_obj_draw.sv
// Object line renderer: scans the object table, fetches 4bpp tile rows and
// writes opaque pixels to a line buffer. Define JTBUBL_OBJ_LIMIT_EN to cap objects per line.
module jtbubl_obj_draw #(
    parameter int OBJN   = 64,
    parameter int CODEW  = 10,
    parameter int PALW   = 4,
    parameter int HEIGHT = 16,
    parameter int MAXOBJ = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_line_start,
    input  logic [7:0]              i_vrender,
    jtbubl_obj_draw_if.master       bus,
    output logic                    o_busy,
    output logic                    o_overflow
);
    localparam int AW = $clog2(OBJN);
    localparam int HB = $clog2(HEIGHT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_FETCH,
        ST_DRAW,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [AW-1:0]     r_obj_addr;
    logic [7:0]        r_vrender;
    logic [CODEW-1:0]  r_code;
    logic [PALW-1:0]   r_pal;
    logic              r_vflip;
    logic              r_hflip;
    logic [8:0]        r_x;
    logic [HB-1:0]     r_dy;
    logic              r_col;
    logic [2:0]        r_k;
    logic              r_first;
    logic [31:0]       r_data;

    logic [7:0]        w_dy;
    logic              w_in_range;
    logic              w_last;
    logic              w_capture;
    logic              w_advance;
    logic              w_overflow;
    logic [2:0]        w_n;
    logic [3:0]        w_pixel;

    assign w_dy       = r_vrender - bus.obj_data[7:0];
    assign w_in_range = (w_dy[7:HB] == '0);
    assign w_last     = (r_obj_addr == AW'(OBJN - 1));
    assign w_capture  = (r_state == ST_FETCH) && !r_first && bus.rom_ok;

    // Horizontal flip reads the fetched row right to left: n = 7 - k.
    assign w_n     = r_k ^ {3{r_hflip}};
    assign w_pixel = r_data[{w_n, 2'b00} +: 4];

`ifdef JTBUBL_OBJ_LIMIT_EN
    localparam int CW = $clog2(MAXOBJ + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_line_start) begin
            r_cnt <= '0;
        end else if (r_state == ST_CHECK && w_in_range && r_cnt != CW'(MAXOBJ)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_limit;
    assign w_unused_limit = (MAXOBJ > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_overflow  = 1'b0;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_READ:  w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (w_in_range) begin
`ifdef JTBUBL_OBJ_LIMIT_EN
                    if (r_cnt == CW'(MAXOBJ)) begin
                        w_overflow  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
`else
                    w_state_nxt = ST_FETCH;
`endif
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_FETCH: if (w_capture) w_state_nxt = ST_DRAW;
            ST_DRAW: begin
                if (r_k == 3'd7) begin
                    if (!r_col) w_state_nxt = ST_FETCH;
                    else        w_advance   = 1'b1;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_advance) w_state_nxt = w_last ? ST_DONE : ST_READ;
        // A new line always wins, whatever is in flight.
        if (i_line_start) w_state_nxt = ST_READ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_obj_addr <= '0;
            r_vrender  <= '0;
            r_code     <= '0;
            r_pal      <= '0;
            r_vflip    <= 1'b0;
            r_hflip    <= 1'b0;
            r_x        <= '0;
            r_dy       <= '0;
            r_col      <= 1'b0;
            r_k        <= '0;
            r_first    <= 1'b0;
            r_data     <= '0;
        end else if (i_line_start) begin
            r_obj_addr <= '0;
            r_vrender  <= i_vrender;
        end else begin
            case (r_state)
                ST_CHECK: begin
                    r_code  <= bus.obj_data[19+PALW +: CODEW];
                    r_pal   <= bus.obj_data[19 +: PALW];
                    r_vflip <= bus.obj_data[18];
                    r_hflip <= bus.obj_data[17];
                    r_x     <= bus.obj_data[16:8];
                    r_dy    <= w_dy[HB-1:0];
                    r_col   <= 1'b0;
                    r_first <= 1'b1;
                end
                ST_FETCH: begin
                    r_first <= 1'b0;
                    if (w_capture) begin
                        r_data <= bus.rom_data;
                        r_k    <= '0;
                    end
                end
                ST_DRAW: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7 && !r_col) begin
                        r_col   <= 1'b1;
                        r_first <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_advance && !w_last) r_obj_addr <= r_obj_addr + 1'b1;
        end
    end

    assign bus.obj_addr  = r_obj_addr;
    assign bus.rom_cs    = (r_state == ST_FETCH) && !i_line_start;
    assign bus.rom_addr  = {r_code, r_dy ^ {HB{r_vflip}}, r_col ^ r_hflip};
    assign bus.line_addr = r_x + {5'd0, r_col, r_k};
    assign bus.line_din  = {r_pal, w_pixel};
    assign bus.line_we   = (r_state == ST_DRAW) && (w_pixel != 4'd0) && !i_line_start;
    assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_overflow    = w_overflow && !i_line_start;
endmodule

// File: tb/tb_jtbubl_obj_draw.sv
// Directed bench for jtbubl_obj_draw: models object RAM, tile ROM and the line buffer,
// and checks fetch addresses, pixel writes, wrap, flips, stalls, abort and the object limit.
module tb_jtbubl_obj_draw;
    localparam int OBJN   = 64;
    localparam int CODEW  = 10;
    localparam int PALW   = 4;
    localparam int HEIGHT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_start = 1'b0;
    logic [7:0] vrender = 8'd0;
    logic       busy;
    logic       overflow;

    always #5 clk = ~clk;

    jtbubl_obj_draw_if #(.OBJN(OBJN), .CODEW(CODEW), .PALW(PALW), .HEIGHT(HEIGHT)) bus();

    jtbubl_obj_draw #(.OBJN(OBJN), .CODEW(CODEW), .PALW(PALW), .HEIGHT(HEIGHT), .MAXOBJ(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_line_start (line_start),
        .i_vrender    (vrender),
        .bus          (bus),
        .o_busy       (busy),
        .o_overflow   (overflow)
    );

    logic [32:0] objMem [0:OBJN-1];
    int          lineBuf [0:511];
    logic [14:0] fetchQ [$];
    int          weCount = 0;
    int          overflowCount = 0;
    int          firstWeAddr = -1;
    int          firstWeDin = -1;
    int          romMode = 0;
    int          stallCycles = 0;
    int          fc = 0;
    logic        prevCs = 1'b0;
    logic [14:0] prevAddr = '0;
    int          passCount = 0;
    int          failCount = 0;
    int          checkCount = 0;

    function automatic logic [32:0] mkEntry(input logic [9:0] code, input logic [3:0] pal,
                                            input logic vf, input logic hf,
                                            input logic [8:0] x, input logic [7:0] y);
        return {code, pal, vf, hf, x, y};
    endfunction

    function automatic logic [31:0] romWord(input logic col);
        if (romMode == 1) return 32'h7654_3210;
        return col ? 32'hFEDC_BA98 : 32'h8765_4321;
    endfunction

    function automatic logic [14:0] fq(input int i);
        if (fetchQ.size() > i) return fetchQ[i];
        return 15'h7FFF;
    endfunction

    always @(posedge clk) bus.obj_data <= objMem[bus.obj_addr];

    // The first FETCH cycle always presents rom_ok with junk data that must be ignored.
    always @(negedge clk) begin
        if (bus.rom_cs) begin
            if (!prevCs || bus.rom_addr != prevAddr) begin
                fc = 0;
                fetchQ.push_back(bus.rom_addr);
            end else begin
                fc++;
            end
            if (fc == 0) begin
                bus.rom_ok   = 1'b1;
                bus.rom_data = 32'h1111_1111;
            end else if (fc <= stallCycles) begin
                bus.rom_ok   = 1'b0;
                bus.rom_data = 32'h2222_2222;
            end else begin
                bus.rom_ok   = 1'b1;
                bus.rom_data = romWord(bus.rom_addr[0]);
            end
        end else begin
            bus.rom_ok   = 1'b0;
            bus.rom_data = 32'h3333_3333;
        end
        prevCs   = bus.rom_cs;
        prevAddr = bus.rom_addr;
        if (bus.line_we) begin
            if (weCount == 0) begin
                firstWeAddr = int'(bus.line_addr);
                firstWeDin  = int'(bus.line_din);
            end
            lineBuf[bus.line_addr] = int'(bus.line_din);
            weCount++;
        end
        if (overflow) overflowCount++;
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] v);
        vrender    = v;
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            cyc();
            n++;
        end
        checkOutput(tag, busy, 0);
    endtask

    task automatic clearBuf();
        for (int i = 0; i < 512; i++) lineBuf[i] = -1;
        weCount = 0;
        overflowCount = 0;
        firstWeAddr = -1;
        firstWeDin = -1;
        fetchQ.delete();
    endtask

    task automatic clearTable();
        for (int i = 0; i < OBJN; i++) objMem[i] = mkEntry(10'd0, 4'd0, 1'b0, 1'b0, 9'd0, 8'hF0);
    endtask

    initial begin
        int n;
        int expObj;
        int expOv;
        int expEnd;
        clearTable();
        clearBuf();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_obj_addr", bus.obj_addr, 0);
        checkOutput("rst_rom_cs", bus.rom_cs, 0);
        checkOutput("rst_line_we", bus.line_we, 0);
        checkOutput("rst_overflow", overflow, 0);

        // Plain object on line 0x25, row 5.
        objMem[3] = mkEntry(10'h055, 4'd2, 1'b0, 1'b0, 9'h010, 8'h20);
        applyStimulus(8'h25);
        checkOutput("t1_busy_up", busy, 1);
        waitIdle("t1_done", 2000);
        checkOutput("t1_end_addr", bus.obj_addr, OBJN - 1);
        checkOutput("t1_nfetch", fetchQ.size(), 2);
        checkOutput("t1_fetch0", fq(0), {10'h055, 4'd5, 1'b0});
        checkOutput("t1_fetch1", fq(1), {10'h055, 4'd5, 1'b1});
        checkOutput("t1_wecount", weCount, 16);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("t1_px%0d", i), lineBuf[16 + i], (i < 8) ? 32'h20 + i + 1 : 32'h20 + i);
        checkOutput("t1_px_after", lineBuf[32], -1);
        repeat (2) cyc();

        // Both flips, constant row data.
        clearBuf();
        romMode = 1;
        objMem[3] = mkEntry(10'h055, 4'd2, 1'b1, 1'b1, 9'h010, 8'h20);
        applyStimulus(8'h25);
        waitIdle("t2_done", 2000);
        checkOutput("t2_fetch0", fq(0), {10'h055, 4'd10, 1'b1});
        checkOutput("t2_fetch1", fq(1), {10'h055, 4'd10, 1'b0});
        checkOutput("t2_wecount", weCount, 14);
        checkOutput("t2_first_addr", firstWeAddr, 32'h010);
        checkOutput("t2_first_din", firstWeDin, 32'h27);
        checkOutput("t2_px16", lineBuf[16'h16], 32'h21);
        checkOutput("t2_px17", lineBuf[16'h17], -1);
        checkOutput("t2_px18", lineBuf[16'h18], 32'h27);
        checkOutput("t2_px1f", lineBuf[16'h1F], -1);
        romMode = 0;
        repeat (2) cyc();

        // Horizontal wrap and vertical wrap (y=0xF8 on line 2 gives dy=10).
        clearBuf();
        objMem[3] = mkEntry(10'h055, 4'd2, 1'b0, 1'b0, 9'h1FC, 8'hF8);
        applyStimulus(8'h02);
        waitIdle("t3_done", 2000);
        checkOutput("t3_fetch0", fq(0), {10'h055, 4'd10, 1'b0});
        checkOutput("t3_wecount", weCount, 16);
        checkOutput("t3_px1fc", lineBuf[16'h1FC], 32'h21);
        checkOutput("t3_px1ff", lineBuf[16'h1FF], 32'h24);
        checkOutput("t3_px000", lineBuf[16'h000], 32'h25);
        checkOutput("t3_px004", lineBuf[16'h004], 32'h28);
        checkOutput("t3_px00b", lineBuf[16'h00B], 32'h2F);
        checkOutput("t3_px00c", lineBuf[16'h00C], -1);
        repeat (2) cyc();

        // ROM stall of 20 cycles after the ignored first cycle.
        clearBuf();
        stallCycles = 20;
        objMem[3] = mkEntry(10'h055, 4'd2, 1'b0, 1'b0, 9'h010, 8'h20);
        applyStimulus(8'h25);
        n = 0;
        while (!bus.rom_cs && n < 500) begin
            cyc();
            n++;
        end
        checkOutput("t4_cs_seen", bus.rom_cs, 1);
        repeat (15) cyc();
        checkOutput("t4_cs_wait", bus.rom_cs, 1);
        checkOutput("t4_no_we", weCount, 0);
        waitIdle("t4_done", 3000);
        checkOutput("t4_wecount", weCount, 16);
        checkOutput("t4_nfetch", fetchQ.size(), 2);
        checkOutput("t4_px10", lineBuf[16'h10], 32'h21);
        checkOutput("t4_px1f", lineBuf[16'h1F], 32'h2F);
        stallCycles = 0;
        repeat (2) cyc();

        // Abort during the draw of entry 10, restart on line 0x40.
        clearTable();
        clearBuf();
        objMem[10] = mkEntry(10'h0AA, 4'd5, 1'b0, 1'b0, 9'h080, 8'h20);
        objMem[20] = mkEntry(10'h011, 4'd7, 1'b0, 1'b0, 9'h100, 8'h40);
        applyStimulus(8'h25);
        n = 0;
        while (!bus.line_we && n < 1000) begin
            cyc();
            n++;
        end
        checkOutput("t5_we_seen", bus.line_we, 1);
        checkOutput("t5_addr10", bus.obj_addr, 10);
        applyStimulus(8'h40);
        checkOutput("t5_we_drop", bus.line_we, 0);
        checkOutput("t5_addr0", bus.obj_addr, 0);
        clearBuf();
        waitIdle("t5_done", 2000);
        checkOutput("t5_wecount", weCount, 16);
        checkOutput("t5_fetch0", fq(0), {10'h011, 4'd0, 1'b0});
        checkOutput("t5_px100", lineBuf[16'h100], 32'h71);
        checkOutput("t5_px10f", lineBuf[16'h10F], 32'h7F);
        checkOutput("t5_px080", lineBuf[16'h080], -1);
        repeat (2) cyc();

        // Twenty objects on one line.
        clearTable();
        clearBuf();
        for (int i = 0; i < 20; i++)
            objMem[i] = mkEntry(10'(i), 4'd1, 1'b0, 1'b0, 9'(i * 16), 8'h30);
`ifdef JTBUBL_OBJ_LIMIT_EN
        expObj = 12;
        expOv  = 1;
        expEnd = 12;
`else
        expObj = 20;
        expOv  = 0;
        expEnd = OBJN - 1;
`endif
        applyStimulus(8'h30);
        waitIdle("t6_done", 5000);
        checkOutput("t6_end_addr", bus.obj_addr, expEnd);
        checkOutput("t6_wecount", weCount, expObj * 16);
        checkOutput("t6_overflow", overflowCount, expOv);
        checkOutput("t6_nfetch", fetchQ.size(), expObj * 2);
        checkOutput("t6_fetch2", fq(2), {10'd1, 4'd0, 1'b0});
        checkOutput("t6_px_e11", lineBuf[11 * 16 + 15], 32'h1F);
        checkOutput("t6_px_e12", lineBuf[12 * 16], (expObj > 12) ? 32'h11 : -1);
        checkOutput("t6_px_e19", lineBuf[19 * 16 + 15], (expObj > 12) ? 32'h1F : -1);
        repeat (2) cyc();
        checkOutput("t6_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
